fu_branch_pipe: RTL and testbench

- Parametrised, pipelined branch/jump resolution unit for the out-of-order core.
- Resolves all RV32I conditional branches plus JAL and JALR, computes the redirect target and link value, and flags mispredicts.
- Buffers results in a 2-entry output queue with valid/ready backpressure toward the ROB/CDB.
- Kills in-flight results younger than a flushing branch.

---
 rtl/fu_branch_pipe.sv | 157 +++++++++++++++
 tb/tb_fu_branch_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_branch_pipe.sv
// Pipelined branch/jump resolution unit with a 2-entry result queue and age-based flush.
// Optional BRANCH_BTB_PRED_EN: compare against front-end prediction instead of static not-taken.
module fu_branch_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        issue_opcode,
    input  logic [2:0]        issue_func3,
    input  logic [XLEN-1:0]   issue_pc,
    input  logic [XLEN-1:0]   issue_imm,
    input  logic [PREG_W-1:0] issue_pd,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    input  logic [XLEN-1:0]   ps1_data,
    input  logic [XLEN-1:0]   ps2_data,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              flush_valid,
    input  logic [ROB_W-1:0]  flush_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROB_W-1:0]  out_rob_idx,
    output logic [PREG_W-1:0] out_pd,
    output logic              out_wr_en,
    output logic [XLEN-1:0]   out_data,
    output logic              out_redirect,
    output logic [XLEN-1:0]   out_target,
    output logic              out_hit
);

    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] pd;
        logic              wr_en;
        logic [XLEN-1:0]   data;
        logic              redirect;
        logic [XLEN-1:0]   target;
        logic              hit;
    } entry_t;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    entry_t     q0_q, q1_q, q0_d, q1_d, new_e;
    logic [1:0] count_q, count_d;

    logic            is_br, is_jal, is_jalr, br_ok, taken, valid_op, redir;
    logic [XLEN-1:0] base, tgt, link;

    // Age relative to the ROB head; modular subtraction handles tag wrap-around.
    function automatic logic younger(input logic [ROB_W-1:0] t, input logic [ROB_W-1:0] head,
                                     input logic [ROB_W-1:0] ref_tag);
        logic [ROB_W-1:0] age_t, age_r;
        age_t = t - head;
        age_r = ref_tag - head;
        return age_t > age_r;
    endfunction

    always_comb begin
        is_br   = (issue_opcode == OpBranch);
        is_jal  = (issue_opcode == OpJal);
        is_jalr = (issue_opcode == OpJalr) && (issue_func3 == 3'b000);
        br_ok   = 1'b1;
        taken   = 1'b0;
        case (issue_func3)
            3'b000:  taken = (ps1_data == ps2_data);
            3'b001:  taken = (ps1_data != ps2_data);
            3'b100:  taken = ($signed(ps1_data) < $signed(ps2_data));
            3'b101:  taken = ($signed(ps1_data) >= $signed(ps2_data));
            3'b110:  taken = (ps1_data < ps2_data);
            3'b111:  taken = (ps1_data >= ps2_data);
            default: br_ok = 1'b0;
        endcase
        if (is_jal || is_jalr) begin
            taken = 1'b1;
        end else if (!is_br) begin
            taken = 1'b0;
        end
        valid_op = (is_br && br_ok) || is_jal || is_jalr;
        base     = is_jalr ? ps1_data : issue_pc;
        tgt      = base + issue_imm;
        tgt[0]   = 1'b0;
        link     = issue_pc + XLEN'(4);

        new_e.rob_idx = issue_rob_idx;
        new_e.pd      = issue_pd;
        new_e.wr_en   = is_jal || is_jalr;
        new_e.data    = (is_jal || is_jalr) ? link : '0;
`ifdef BRANCH_BTB_PRED_EN
        redir          = (taken != pred_taken) || (taken && (pred_target != tgt));
        new_e.target   = (pred_taken && !taken) ? link : tgt;
`else
        redir          = taken;
        new_e.target   = tgt;
`endif
        new_e.redirect = valid_op && redir;
        new_e.hit      = valid_op && !redir;
    end

`ifndef BRANCH_BTB_PRED_EN
    logic unused_pred;
    assign unused_pred = ^{pred_taken, pred_target};
`endif

    logic head_valid, kill0, kill1, kill_new, pop, keep0, keep1, push;

    always_comb begin
        head_valid  = (count_q != 2'd0);
        kill0       = flush_valid && younger(q0_q.rob_idx, rob_head, flush_tag);
        kill1       = flush_valid && younger(q1_q.rob_idx, rob_head, flush_tag);
        kill_new    = flush_valid && younger(issue_rob_idx, rob_head, flush_tag);
        issue_ready = (count_q != 2'd2);
        out_valid   = head_valid && !kill0;
        pop         = out_valid && out_ready;
        keep0       = head_valid && !kill0 && !pop;
        keep1       = (count_q == 2'd2) && !kill1;
        push        = issue_valid && issue_ready && !kill_new;

        // Survivors compact toward the head, new op lands behind them.
        if (keep0) begin
            q0_d = q0_q;
        end else if (keep1) begin
            q0_d = q1_q;
        end else begin
            q0_d = new_e;
        end
        q1_d    = (keep0 && keep1) ? q1_q : new_e;
        count_d = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};

        out_rob_idx  = head_valid ? q0_q.rob_idx : '0;
        out_pd       = head_valid ? q0_q.pd : '0;
        out_wr_en    = head_valid && q0_q.wr_en;
        out_data     = head_valid ? q0_q.data : '0;
        out_redirect = head_valid && q0_q.redirect;
        out_target   = head_valid ? q0_q.target : '0;
        out_hit      = head_valid && q0_q.hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q0_q    <= '0;
            q1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Self-checking bench for fu_branch_pipe: vector table plus scoreboard, with flush/reset sequences.
module tb_fu_branch_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_func3;
    logic [31:0] issue_pc, issue_imm, ps1_data, ps2_data, pred_target;
    logic [6:0]  issue_pd;
    logic [4:0]  issue_rob_idx, rob_head, flush_tag;
    logic        pred_taken, flush_valid;
    logic        out_valid, out_ready, out_wr_en, out_redirect, out_hit;
    logic [4:0]  out_rob_idx;
    logic [6:0]  out_pd;
    logic [31:0] out_data, out_target;

    fu_branch_pipe #(.XLEN(32), .ROB_W(5), .PREG_W(7)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_func3(issue_func3),
        .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_pd(issue_pd),
        .issue_rob_idx(issue_rob_idx), .ps1_data(ps1_data), .ps2_data(ps2_data),
        .pred_taken(pred_taken), .pred_target(pred_target), .rob_head(rob_head),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_idx(out_rob_idx),
        .out_pd(out_pd), .out_wr_en(out_wr_en), .out_data(out_data),
        .out_redirect(out_redirect), .out_target(out_target), .out_hit(out_hit)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] pc, imm, ps1, ps2;
        logic [6:0]  pd;
        logic [4:0]  tag;
        logic        redirect, hit, wr_en;
        logic [31:0] data, target;
        logic        chk_tgt;
    } vec_t;

    vec_t tbl[12];
    vec_t v;
    vec_t exp_q[$];
    vec_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: actual tag=%0d required no output", out_rob_idx);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("result tag %0d", mon_e.tag),
                      {out_rob_idx, out_pd, out_wr_en, out_data, out_redirect,
                       mon_e.chk_tgt ? out_target : 32'h0, out_hit},
                      {mon_e.tag, mon_e.pd, mon_e.wr_en, mon_e.data, mon_e.redirect,
                       mon_e.chk_tgt ? mon_e.target : 32'h0, mon_e.hit});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one op; the expected result is queued only if it will be accepted and kept.
    task automatic issue(input vec_t x, input logic keep);
        issue_opcode  = x.opc;
        issue_func3   = x.f3;
        issue_pc      = x.pc;
        issue_imm     = x.imm;
        ps1_data      = x.ps1;
        ps2_data      = x.ps2;
        issue_pd      = x.pd;
        issue_rob_idx = x.tag;
        issue_valid   = 1'b1;
        if (issue_ready && keep) exp_q.push_back(x);
        step();
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        check({name, " drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{BR, 3'b001, 32'h100, 32'h20, 32'd5, 32'd3, 7'd1, 5'd0,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h120, 1'b1};
        tbl[1]  = '{BR, 3'b100, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1, 7'd2, 5'd1,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h120, 1'b1};
        tbl[2]  = '{BR, 3'b110, 32'h100, 32'h20, 32'hFFFFFFFF, 32'd1, 7'd3, 5'd2,
                    1'b0, 1'b1, 1'b0, 32'h0, 32'h120, 1'b1};
        tbl[3]  = '{JALR, 3'b000, 32'h200, 32'd4, 32'h1003, 32'h0, 7'd9, 5'd3,
                    1'b1, 1'b0, 1'b1, 32'h204, 32'h1006, 1'b1};
        tbl[4]  = '{BR, 3'b000, 32'h300, 32'hFFFFFFF1, 32'd7, 32'd7, 7'd4, 5'd4,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h2F0, 1'b1};
        tbl[5]  = '{BR, 3'b101, 32'h400, 32'h8, 32'h80000000, 32'h0, 7'd5, 5'd5,
                    1'b0, 1'b1, 1'b0, 32'h0, 32'h408, 1'b1};
        tbl[6]  = '{BR, 3'b111, 32'h400, 32'h8, 32'h80000000, 32'h0, 7'd6, 5'd6,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h408, 1'b1};
        tbl[7]  = '{JAL, 3'b000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 7'd7, 5'd7,
                    1'b1, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1};
        tbl[8]  = '{BR, 3'b010, 32'h100, 32'h20, 32'd1, 32'd1, 7'd8, 5'd8,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[9]  = '{JALR, 3'b001, 32'h100, 32'h20, 32'h50, 32'h0, 7'd10, 5'd9,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[10] = '{BR, 3'b001, 32'h500, 32'h40, 32'd3, 32'd3, 7'd11, 5'd10,
                    1'b0, 1'b1, 1'b0, 32'h0, 32'h540, 1'b1};
        tbl[11] = '{7'b0110011, 3'b000, 32'h600, 32'h4, 32'd1, 32'd2, 7'd12, 5'd11,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};

        reset = 1'b1; issue_valid = 1'b0; issue_opcode = '0; issue_func3 = '0;
        issue_pc = '0; issue_imm = '0; ps1_data = '0; ps2_data = '0; issue_pd = '0;
        issue_rob_idx = '0; pred_taken = 1'b0; pred_target = '0; rob_head = '0;
        flush_valid = 1'b0; flush_tag = '0; out_ready = 1'b1;
        step();
        step();
        check("reset out_valid", out_valid, 0);
        check("reset issue_ready", issue_ready, 1);
        check("reset out fields",
              {out_rob_idx, out_pd, out_wr_en, out_data, out_redirect, out_target, out_hit}, 0);
        reset = 1'b0;
        step();

        // Single op: visible the cycle after acceptance.
        issue(tbl[0], 1'b1);
        issue_valid = 1'b0;
        check("latency out_valid", out_valid, 1);
        step();
        for (int i = 1; i < 12; i++) issue(tbl[i], 1'b1);
        issue_valid = 1'b0;
        drain("table");

        // Backpressure: two results held, then drained in order.
        out_ready = 1'b0;
        issue(tbl[3], 1'b1);
        issue(tbl[0], 1'b1);
        issue_valid = 1'b0;
        check("full issue_ready", issue_ready, 0);
        step();
        step();
        check("held head tag", {out_valid, out_rob_idx}, {1'b1, 5'd3});
        out_ready = 1'b1;
        step();
        check("ready after pop", issue_ready, 1);
        drain("backpressure");

        // Flush across the tag wrap with rob_head=30.
        rob_head = 5'd30;
        out_ready = 1'b0;
        v = tbl[0]; v.tag = 5'd31; issue(v, 1'b1);
        v = tbl[3]; v.tag = 5'd1;  issue(v, 1'b1);
        flush_valid = 1'b1; flush_tag = 5'd0;
        v = tbl[1]; v.tag = 5'd2; issue(v, 1'b0);
        void'(exp_q.pop_back());
        flush_valid = 1'b0; issue_valid = 1'b0;
        check("flush survivor head", {out_valid, out_rob_idx, issue_ready}, {1'b1, 5'd31, 1'b1});
        flush_valid = 1'b1;
        v = tbl[1]; v.tag = 5'd2; issue(v, 1'b0);
        v = tbl[7]; v.tag = 5'd0; issue(v, 1'b1);
        flush_valid = 1'b0; issue_valid = 1'b0;
        check("flush drop then keep equal", issue_ready, 0);
        drain("flush wrap");

        // Killed head must not be presented or popped.
        out_ready = 1'b0;
        v = tbl[2]; v.tag = 5'd1; issue(v, 1'b1);
        issue_valid = 1'b0;
        flush_valid = 1'b1; flush_tag = 5'd0; out_ready = 1'b1;
        #1;
        check("killed head masked", out_valid, 0);
        void'(exp_q.pop_back());
        step();
        flush_valid = 1'b0;
        check("after head kill", {out_valid, issue_ready}, {1'b0, 1'b1});

`ifdef BRANCH_BTB_PRED_EN
        rob_head = 5'd0;
        pred_taken = 1'b1; pred_target = 32'h120;
        v = '{BR, 3'b000, 32'h100, 32'h20, 32'd4, 32'd4, 7'd13, 5'd12,
              1'b0, 1'b1, 1'b0, 32'h0, 32'h120, 1'b1};
        issue(v, 1'b1);
        v = '{BR, 3'b001, 32'h100, 32'h20, 32'd4, 32'd4, 7'd14, 5'd13,
              1'b1, 1'b0, 1'b0, 32'h0, 32'h104, 1'b1};
        issue(v, 1'b1);
        issue_valid = 1'b0; pred_taken = 1'b0; pred_target = '0;
        drain("prediction");
`endif

        // Asynchronous reset with the queue full.
        rob_head = 5'd0;
        out_ready = 1'b0;
        issue(tbl[4], 1'b1);
        issue(tbl[5], 1'b1);
        issue_valid = 1'b0;
        check("pre-reset full", {out_valid, issue_ready}, {1'b1, 1'b0});
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("async reset", {out_valid, issue_ready, out_rob_idx, out_data}, {1'b0, 1'b1, 37'h0});
        step();
        reset = 1'b0;
        step();
        check("post-reset idle", {out_valid, issue_ready}, {1'b0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
